// File: rtl/usb_defs_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_defs_pkg : PID codes, endpoint constants, status and state encodings
// Rev 1.0
// ---------------------------------------------------------------------------
package usb_defs_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_NAK   = 4'hA;

  localparam int         EP_W      = 4;
  localparam logic [3:0] EP_CTRL   = 4'd0;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NAK     = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_LEN_ERR = 2'd3
  } xfer_status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TOKEN    = 3'd1,
    S_TOK_GAP  = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_GAP = 3'd4,
    S_WAIT_RSP = 3'd5,
    S_RX       = 3'd6,
    S_DONE     = 3'd7
  } xfer_state_e;

endpackage
`default_nettype wire

// File: rtl/usb_host_toggle_tbl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_host_toggle_tbl : per-endpoint DATA0/DATA1 toggle bits, read + flip port
// Rev 1.0
// ---------------------------------------------------------------------------
module usb_host_toggle_tbl #(
  parameter int NUM_EP = 16,
  parameter int EP_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [EP_W-1:0] i_rd_ep,
  output logic            o_rd_bit,
  input  logic            i_flip,
  input  logic [EP_W-1:0] i_flip_ep
);

  logic [NUM_EP-1:0] w_tog;

  for (genvar i = 0; i < NUM_EP; i++) begin : g_tog
    logic r_bit;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_bit <= 1'b0;
      end else if (i_flip && (i_flip_ep == EP_W'(i))) begin
        r_bit <= ~r_bit;
      end
    end
    assign w_tog[i] = r_bit;
  end

  // Endpoints beyond NUM_EP read as DATA0
  always_comb begin
    o_rd_bit = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (i_rd_ep == EP_W'(i)) o_rd_bit = w_tog[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_host_xfer_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_host_xfer_engine : one-at-a-time OUT/IN transaction initiator
// Rev 1.0
// ---------------------------------------------------------------------------
module usb_host_xfer_engine
  import usb_defs_pkg::*;
#(
  parameter int MAX_PKT = 64,
  parameter int TIMEOUT = 256,
  parameter int NUM_EP  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [6:0]  cmd_addr,
  input  logic [3:0]  cmd_ep,
  input  logic [15:0] cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  status,
  output logic [15:0] rx_count,
  output logic        pkt_valid,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  ep,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic [15:0] data_len,
  output logic        crc_err,
  input  logic        dev_tx_valid,
  input  logic [3:0]  dev_tx_pid,
  input  logic [7:0]  dev_tx_data,
  input  logic [15:0] dev_tx_len
);

  localparam logic [15:0] c_max_len  = 16'(MAX_PKT);
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

  xfer_state_e  r_state, w_next;
  logic         r_pend, r_cmd_dir, r_dstb;
  logic [6:0]   r_cmd_addr;
  logic [3:0]   r_cmd_ep;
  logic [15:0]  r_cmd_len, r_cnt, r_n;
  logic         w_accept, w_consume, w_flip, w_tog;
  logic [15:0]  w_cnt_inc, w_rx_n;

  logic         r_cmd_ready, r_pkt_valid, r_hdv, r_rd_valid, r_done;
  logic [3:0]   r_pid, r_hep;
  logic [6:0]   r_haddr;
  logic [7:0]   r_hdata, r_rd_data;
  logic [15:0]  r_hlen, r_rx_count;
  xfer_status_e r_status;

  logic         w_cmd_ready, w_pkt_valid, w_hdv, w_rd_valid, w_done;
  logic [3:0]   w_pid, w_hep;
  logic [6:0]   w_haddr;
  logic [7:0]   w_hdata, w_rd_data;
  logic [15:0]  w_hlen, w_rx_count;
  xfer_status_e w_status;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_consume = (r_state == S_DATA) && !r_dstb && wr_valid;
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_rx_n    = (dev_tx_len > c_max_len) ? c_max_len : dev_tx_len;
  assign wr_ready  = w_consume;

  assign w_flip = ((r_state == S_DATA_GAP) && (w_cnt_inc == r_cmd_len)) ||
                  ((r_state == S_RX) && (w_cnt_inc == r_n)) ||
                  ((r_state == S_WAIT_RSP) && dev_tx_valid &&
                   (dev_tx_pid != PID_NAK) && (w_rx_n == 16'd0));

  usb_host_toggle_tbl #(.NUM_EP(NUM_EP), .EP_W(EP_W)) u_toggle (
    .clk      (clk),
    .rst      (rst),
    .i_rd_ep  (r_cmd_ep),
    .o_rd_bit (w_tog),
    .i_flip   (w_flip),
    .i_flip_ep(r_cmd_ep)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (r_pend) w_next = (!r_cmd_dir && (r_cmd_len > c_max_len)) ? S_DONE : S_TOKEN;
      S_TOKEN:    w_next = S_TOK_GAP;
      S_TOK_GAP:  begin
        if (r_cmd_dir)                w_next = S_WAIT_RSP;
        else if (r_cmd_len == 16'd0)  w_next = S_DONE;
        else                          w_next = S_DATA;
      end
      S_DATA:     if (r_dstb) w_next = S_DATA_GAP;
      S_DATA_GAP: w_next = (w_cnt_inc == r_cmd_len) ? S_DONE : S_DATA;
      // A response arriving on the last timeout cycle still wins
      S_WAIT_RSP: begin
        if (dev_tx_valid)
          w_next = ((dev_tx_pid == PID_NAK) || (w_rx_n == 16'd0)) ? S_DONE : S_RX;
        else if (r_cnt == c_tmo_last)
          w_next = S_DONE;
      end
      S_RX:       if (w_cnt_inc == r_n) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_cmd_dir  <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_ep   <= '0;
      r_cmd_len  <= '0;
      r_dstb     <= 1'b0;
      r_cnt      <= '0;
      r_n        <= '0;
    end else begin
      if (w_accept) begin
        r_pend     <= 1'b1;
        r_cmd_dir  <= cmd_dir;
        r_cmd_addr <= cmd_addr;
        r_cmd_ep   <= cmd_ep;
        r_cmd_len  <= cmd_len;
      end else if (r_state == S_IDLE) begin
        r_pend <= 1'b0;
      end
      r_dstb <= w_consume;
      if ((r_state == S_TOK_GAP) || ((r_state == S_WAIT_RSP) && dev_tx_valid))
        r_cnt <= '0;
      else if ((r_state == S_DATA_GAP) || (r_state == S_RX) || (r_state == S_WAIT_RSP))
        r_cnt <= w_cnt_inc;
      if ((r_state == S_WAIT_RSP) && dev_tx_valid) r_n <= w_rx_n;
    end
  end

  // Next values of the registered outputs
  always_comb begin
    w_cmd_ready = (w_next == S_IDLE) && !w_accept;
    w_pkt_valid = 1'b0;
    w_pid       = '0;
    w_haddr     = '0;
    w_hep       = '0;
    w_hdata     = '0;
    w_hdv       = 1'b0;
    w_hlen      = '0;
    w_rd_valid  = 1'b0;
    w_rd_data   = '0;
    w_done      = (w_next == S_DONE);
    w_status    = r_status;
    w_rx_count  = w_accept ? 16'd0 : r_rx_count;
    if (w_next == S_TOKEN) begin
      w_pkt_valid = 1'b1;
      w_pid       = r_cmd_dir ? PID_IN : PID_OUT;
      w_haddr     = r_cmd_addr;
      w_hep       = r_cmd_ep;
      w_hlen      = r_cmd_dir ? 16'd0 : r_cmd_len;
    end
    if (w_consume) begin
      w_pkt_valid = 1'b1;
      w_hdv       = 1'b1;
      w_pid       = w_tog ? PID_DATA1 : PID_DATA0;
      w_haddr     = r_cmd_addr;
      w_hep       = r_cmd_ep;
      w_hdata     = wr_data;
      w_hlen      = r_cmd_len;
    end
    if (r_state == S_RX) begin
      w_rd_valid = 1'b1;
      w_rd_data  = dev_tx_data;
    end
    if (w_done) begin
      unique case (r_state)
        S_IDLE:     w_status = ST_LEN_ERR;
        S_WAIT_RSP: begin
          if (!dev_tx_valid)                w_status = ST_TIMEOUT;
          else if (dev_tx_pid == PID_NAK)   w_status = ST_NAK;
          else                              w_status = ST_OK;
        end
        default:    w_status = ST_OK;
      endcase
      if (r_state == S_RX) w_rx_count = r_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_ready <= 1'b1;
      r_pkt_valid <= 1'b0;
      r_pid       <= '0;
      r_haddr     <= '0;
      r_hep       <= '0;
      r_hdata     <= '0;
      r_hdv       <= 1'b0;
      r_hlen      <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_status    <= ST_OK;
      r_rx_count  <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready;
      r_pkt_valid <= w_pkt_valid;
      r_pid       <= w_pid;
      r_haddr     <= w_haddr;
      r_hep       <= w_hep;
      r_hdata     <= w_hdata;
      r_hdv       <= w_hdv;
      r_hlen      <= w_hlen;
      r_rd_valid  <= w_rd_valid;
      r_rd_data   <= w_rd_data;
      r_done      <= w_done;
      r_status    <= w_status;
      r_rx_count  <= w_rx_count;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign pkt_valid  = r_pkt_valid;
  assign pid        = r_pid;
  assign addr       = r_haddr;
  assign ep         = r_hep;
  assign data       = r_hdata;
  assign data_valid = r_hdv;
  assign data_len   = r_hlen;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign done       = r_done;
  assign status     = r_status;
  assign rx_count   = r_rx_count;
  assign crc_err    = 1'b0;

endmodule
`default_nettype wire

// File: doc/usb_host_xfer_engine.md
Name: usb_host_xfer_engine

Overview:
- Synthesizable host-side transaction initiator. It drives the host packet interface of usb_top, which is the device responder, and collects the device's IN responses.
- It takes one OUT or IN command at a time. It serialises the token and payload bytes into the device's host_* strobe protocol.
- For IN commands it captures the device's host_tx_* response bytes into an output stream.
- Used as a bus-functional master in system benches and as the host-side block of FPGA loopback builds.

Parameters:
- MAX_PKT, 64, largest legal payload in bytes.
- TIMEOUT, 256, cycles to wait for dev_tx_valid after an IN token.
- NUM_EP, 16, number of endpoints that have a tracked data toggle.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; command accepted when cmd_valid and cmd_ready are both high.
- cmd_dir  in  1  0 = OUT, 1 = IN.
- cmd_addr  in  7  device address.
- cmd_ep  in  4  endpoint number.
- cmd_len  in  16  OUT payload length; ignored for IN.
- wr_data  in  8  OUT payload byte.
- wr_valid  in  1  payload byte available.
- wr_ready  out  1  payload byte consumed this cycle.
- rd_data  out  8  captured IN byte.
- rd_valid  out  1  rd_data is valid this cycle; no backpressure.
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done: 0 = OK, 1 = NAK, 2 = TIMEOUT, 3 = LEN_ERR.
- rx_count  out  16  bytes received on the last IN; held until the next command.
- pkt_valid  out  1  to dut host_pkt_valid.
- pid  out  4  to dut host_pid.
- addr  out  7  to dut host_addr.
- ep  out  4  to dut host_ep.
- data  out  8  to dut host_data.
- data_valid  out  1  to dut host_data_valid.
- data_len  out  16  to dut host_data_len.
- crc_err  out  1  to dut host_crc_err; tied to 0.
- dev_tx_valid  in  1  from dut host_tx_valid.
- dev_tx_pid  in  4  from dut host_tx_pid.
- dev_tx_data  in  8  from dut host_tx_data.
- dev_tx_len  in  16  from dut host_tx_len.

Behaviour:
- Reset values:
  - All outputs are 0 except cmd_ready = 1.
  - State is IDLE and all toggle bits are cleared (DATA0).
  - Reset asserted in any state aborts the transfer immediately; no done pulse is generated.
- All outputs are registered.
- Command latch: on accept, cmd_dir, cmd_addr, cmd_ep and cmd_len are latched and cmd_ready drops.
- State IDLE -> TOKEN:
  - If cmd_dir = 0 and cmd_len > MAX_PKT, go to DONE with status LEN_ERR; no pkt_valid is ever driven.
  - Otherwise go to TOKEN.
- State TOKEN, one cycle:
  - pkt_valid = 1; pid = PID_OUT or PID_IN; addr and ep from the latched command.
  - data_len = cmd_len for OUT, 0 for IN.
  - Next state: TOK_GAP.
- State TOK_GAP, one cycle, all strobes 0:
  - OUT with len 0 -> DONE with status OK.
  - OUT with len > 0 -> DATA.
  - IN -> WAIT_RSP.
- State DATA:
  - Wait for wr_valid; wr_ready is combinationally equal to wr_valid in this state.
  - On a consumed byte, the next cycle drives pkt_valid = 1, data_valid = 1, data = byte and pid = DATA0 or DATA1 from toggle[ep]. Then go to DATA_GAP.
  - Stalls of any length are allowed; no strobes are driven while stalled.
- State DATA_GAP, one cycle idle:
  - Byte counter increments.
  - If count = len, flip toggle[ep] and go to DONE with status OK; otherwise return to DATA.
- State WAIT_RSP:
  - Counter runs from 0.
  - On dev_tx_valid = 1:
    - If dev_tx_pid = PID_NAK, go to DONE with status NAK and rx_count = 0.
    - Otherwise latch N = dev_tx_len, clamped to MAX_PKT, and go to RX.
  - If the counter reaches TIMEOUT-1 with no dev_tx_valid, go to DONE with status TIMEOUT.
  - If dev_tx_valid arrives in the same cycle as the timeout, dev_tx_valid wins.
- State RX:
  - On each of the N cycles following detection, sample dev_tx_data.
  - Sampled bytes appear on rd_data with rd_valid one cycle later.
  - If N = 0, go to DONE immediately.
  - After N bytes, set rx_count = N, flip toggle[ep], and go to DONE with status OK.
- State DONE, one cycle:
  - done = 1 and status is valid.
  - cmd_ready returns to 1 on the next cycle.
- A command presented while busy is simply not accepted; there is no queueing.
- Counters are 16-bit and never wrap, because lengths are bounded by MAX_PKT.

Decomposition:
- usb_defs_pkg:
  - PID_OUT = 4'h1, PID_IN = 4'h9, PID_DATA0 = 4'h3, PID_DATA1 = 4'hB, PID_NAK = 4'hA.
  - EP constants.
  - Enum xfer_status_e.
  - Enum for the states IDLE, TOKEN, TOK_GAP, DATA, DATA_GAP, WAIT_RSP, RX, DONE.
- One sub-module, usb_host_toggle_tbl: NUM_EP toggle bits with a read port and a flip port, cleared on reset.

Test Plan:
- Reset held for 5 cycles -> all outputs 0, cmd_ready = 1, no pkt_valid for 10 cycles after release.
- OUT to addr 0, ep 1, len 8, payload A1..A8 -> one token cycle (pid 1, ep 1, data_len 8). Then 8 data strobes, each followed by a gap cycle, with pid 3. Then done with status 0. A repeat OUT uses pid B.
- IN to ep 1 with the device answering valid, len 8, bytes A1..A8 -> rd_valid 8 times with A1..A8 in order, done with status OK, rx_count 8.
- IN to ep 2 with the device silent -> done with status TIMEOUT exactly TIMEOUT cycles after entering WAIT_RSP. A device answering NAK instead -> status NAK, rx_count 0.
- OUT with cmd_len 65 -> done with status LEN_ERR two cycles after accept, pkt_valid never asserted. OUT with len 0 -> token cycle only, then status OK.
- wr_valid dropped for 4 cycles after byte 3 -> no strobe during the stall and payload order kept. rst pulsed during RX -> IDLE next cycle, no done pulse, toggles cleared.
